// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise data has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_idle,
    input  logic i_req_f,
    input  logic i_req_d,
`ifdef MEM_ARB_RR_EN
    input  logic i_last,
`endif
    output logic o_gnt_f,
    output logic o_gnt_d
);

    // Grants only while idle, at most one, only to a requesting port
    always_comb begin
        o_gnt_f = 1'b0;
        o_gnt_d = 1'b0;
        if (i_idle) begin
            if (i_req_f && i_req_d) begin
`ifdef MEM_ARB_RR_EN
                if (i_last == REQ_DATA) begin
                    o_gnt_f = 1'b1;
                end else begin
                    o_gnt_d = 1'b1;
                end
`else
                o_gnt_d = 1'b1;
`endif
            end else begin
                o_gnt_f = i_req_f;
                o_gnt_d = i_req_d;
            end
        end else begin
            o_gnt_f = 1'b0;
            o_gnt_d = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter (fetch read-only, data read/write).
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration on ties.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_f,
    input  logic [ADDR_W-1:0] addr_f,
    output logic              gnt_f,
    output logic              done_f,
    input  logic              req_d,
    input  logic              we_d,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    output logic              gnt_d,
    output logic              done_d,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done_f;
    logic                r_done_d;
    logic                w_gnt_f;
    logic                w_gnt_d;
    logic                w_accept;
    logic                w_finish;
    logic                w_idle;
`ifdef MEM_ARB_RR_EN
    logic                r_last;
`endif

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_gnt_f | w_gnt_d;

    mem_arb_pick u_pick (
        .i_idle  (w_idle),
        .i_req_f (req_f),
        .i_req_d (req_d),
`ifdef MEM_ARB_RR_EN
        .i_last  (r_last),
`endif
        .o_gnt_f (w_gnt_f),
        .o_gnt_d (w_gnt_d)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; an access finishes on the edge where the wait counter is already zero
    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latches, wait counter, read data capture and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_owner  <= REQ_FETCH;
            r_we     <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_wdata  <= {DATA_W{1'b0}};
            r_rdata  <= {DATA_W{1'b0}};
            r_done_f <= 1'b0;
            r_done_d <= 1'b0;
        end else begin
            r_done_f <= 1'b0;
            r_done_d <= 1'b0;
            if (w_accept) begin
                r_owner <= w_gnt_d ? REQ_DATA : REQ_FETCH;
                r_we    <= w_gnt_d & we_d;
                r_addr  <= w_gnt_d ? addr_d : addr_f;
                r_wdata <= w_gnt_d ? wdata_d : {DATA_W{1'b0}};
                r_cnt   <= WAIT_LD;
            end else if (w_finish) begin
                if (!r_we) begin
                    r_rdata <= mem_rdata;
                end
                r_done_f <= (r_owner == REQ_FETCH);
                r_done_d <= (r_owner == REQ_DATA);
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer: remembers which port won the last acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ_DATA;
        end else if (w_accept) begin
            r_last <= w_gnt_d ? REQ_DATA : REQ_FETCH;
        end
    end
`endif

    assign gnt_f     = w_gnt_f;
    assign gnt_d     = w_gnt_d;
    assign done_f    = r_done_f;
    assign done_d    = r_done_d;
    assign rdata     = r_rdata;
    assign busy      = (r_state == ST_ACCESS);
    assign mem_en    = (r_state == ST_ACCESS);
    assign mem_we    = (r_state == ST_ACCESS) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: one instance with WAIT_CYC=1, one with WAIT_CYC=0.
module tb_mem_port_arbiter;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_f, req_d, we_d;
    logic [7:0]  addr_f, addr_d;
    logic [15:0] wdata_d;
    logic        gnt_f, gnt_d, done_f, done_d, busy, mem_en, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic        req_f0, req_d0, we_d0;
    logic [7:0]  addr_f0, addr_d0;
    logic [15:0] wdata_d0;
    logic        gnt_f0, gnt_d0, done_f0, done_d0, busy0, mem_en0, mem_we0;
    logic [15:0] rdata0, mem_wdata0, mem_rdata0;
    logic [7:0]  mem_addr0;

    typedef struct {
        logic        owner;
        logic        we;
        logic [15:0] rd;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic        grant_log[$];
    logic [15:0] exp_rd;
    int          cyc;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [7:0] a);
        if (a == 8'h10) return 16'h1234;
        else return {a, ~a};
    endfunction

    assign mem_rdata  = mem_val(mem_addr);
    assign mem_rdata0 = mem_val(mem_addr0);

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_f(req_f), .addr_f(addr_f), .gnt_f(gnt_f), .done_f(done_f),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .gnt_d(gnt_d), .done_d(done_d), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_f(req_f0), .addr_f(addr_f0), .gnt_f(gnt_f0), .done_f(done_f0),
        .req_d(req_d0), .we_d(we_d0), .addr_d(addr_d0), .wdata_d(wdata_d0),
        .gnt_d(gnt_d0), .done_d(done_d0), .rdata(rdata0), .busy(busy0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants plus scoreboard push on acceptance and pop on done
    task automatic settle();
        exp_t e;
        #1;
        chk("gnt_onehot", {31'd0, gnt_f & gnt_d}, 32'd0);
        chk("gnt_in_access", {31'd0, (gnt_f | gnt_d) & busy}, 32'd0);
        chk("gnt_no_req", {31'd0, (gnt_f & ~req_f) | (gnt_d & ~req_d)}, 32'd0);
        chk("done_excl", {31'd0, done_f & done_d}, 32'd0);
        chk("mem_en_busy", {31'd0, mem_en}, {31'd0, busy});
        chk("mem_we_idle", {31'd0, mem_we & ~busy}, 32'd0);
        if (done_f || done_d) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", {30'd0, done_f, done_d}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("done_owner", {31'd0, done_d}, {31'd0, e.owner});
                chk("done_cycle", cyc, e.due);
                if (e.we) begin
                    chk("rdata_write_kept", {16'd0, rdata}, {16'd0, exp_rd});
                end else begin
                    chk("rdata_read", {16'd0, rdata}, {16'd0, e.rd});
                    exp_rd = e.rd;
                end
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("done_missing", {31'd0, done_f | done_d}, 32'd1);
            void'(sbq.pop_front());
        end
        if (rst) begin
            sbq.delete();
            exp_rd = 16'h0000;
        end else if ((gnt_f && req_f) || (gnt_d && req_d)) begin
            e.owner = gnt_d;
            e.we    = gnt_d ? we_d : 1'b0;
            e.rd    = mem_val(gnt_d ? addr_d : addr_f);
            e.due   = cyc + WAIT + 2;
            sbq.push_back(e);
            grant_log.push_back(gnt_d);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        int we_cnt;
        int dn_cnt;
        n_tests = 0; n_fail = 0; cyc = 0; exp_rd = 16'h0000;
        rst = 1'b1;
        req_f = 1'b0; req_d = 1'b0; we_d = 1'b0; addr_f = 8'h00; addr_d = 8'h00; wdata_d = 16'h0000;
        req_f0 = 1'b0; req_d0 = 1'b0; we_d0 = 1'b0; addr_f0 = 8'h00; addr_d0 = 8'h00; wdata_d0 = 16'h0000;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset values
        settle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_done", {30'd0, done_f, done_d}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
        adv();

        // Fetch read of 0x10
        req_f = 1'b1; addr_f = 8'h10;
        settle();
        chk("f_gnt_f", {31'd0, gnt_f}, 32'd1);
        chk("f_gnt_d", {31'd0, gnt_d}, 32'd0);
        adv();
        req_f = 1'b0;
        settle();
        chk("f_busy", {31'd0, busy}, 32'd1);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_mem_addr", {24'd0, mem_addr}, 32'h10);
        adv();
        step();
        settle();
        chk("f_done_c3", {31'd0, done_f}, 32'd1);
        chk("f_rdata", {16'd0, rdata}, 32'h1234);
        adv();

        // Data write of 0xBEEF at 0x20
        req_d = 1'b1; we_d = 1'b1; addr_d = 8'h20; wdata_d = 16'hBEEF;
        settle();
        chk("w_gnt_d", {31'd0, gnt_d}, 32'd1);
        adv();
        req_d = 1'b0; we_d = 1'b0;
        we_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (mem_we && mem_addr == 8'h20 && mem_wdata == 16'hBEEF) we_cnt++;
            if (done_d) dn_cnt++;
            adv();
        end
        chk("w_mem_we_cycles", we_cnt, 2);
        chk("w_done_count", dn_cnt, 1);
        chk("w_rdata_kept", {16'd0, rdata}, 32'h1234);

        // Both requesters held for four acceptances
        grant_log.delete();
        req_f = 1'b1; addr_f = 8'h30;
        req_d = 1'b1; we_d = 1'b0; addr_d = 8'h40;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
        req_f = 1'b0; req_d = 1'b0;
        repeat (6) step();
        chk("tie_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef MEM_ARB_RR_EN
            chk("tie_order_rr", {31'd0, grant_log[i]}, i % 2);
`else
            chk("tie_order_fixed", {31'd0, grant_log[i]}, 32'd1);
`endif
        end

        // WAIT_CYC=0 instance: back-to-back data reads of 0x01 and 0x02
        req_d0 = 1'b1; we_d0 = 1'b0; addr_d0 = 8'h01;
        settle();
        chk("z_gnt_c0", {31'd0, gnt_d0}, 32'd1);
        adv();
        addr_d0 = 8'h02;
        settle();
        chk("z_gnt_c1", {31'd0, gnt_d0}, 32'd0);
        chk("z_addr_c1", {24'd0, mem_addr0}, 32'h01);
        adv();
        settle();
        chk("z_done_c2", {31'd0, done_d0}, 32'd1);
        chk("z_rdata_c2", {16'd0, rdata0}, 32'h01FE);
        chk("z_gnt_c2", {31'd0, gnt_d0}, 32'd1);
        adv();
        req_d0 = 1'b0;
        settle();
        chk("z_done_c3", {31'd0, done_d0}, 32'd0);
        chk("z_addr_c3", {24'd0, mem_addr0}, 32'h02);
        adv();
        settle();
        chk("z_done_c4", {31'd0, done_d0}, 32'd1);
        chk("z_rdata_c4", {16'd0, rdata0}, 32'h02FD);
        adv();
        settle();
        chk("z_idle_c5", {30'd0, busy0, done_d0}, 32'd0);
        adv();

        // Reset in the second access cycle aborts the transaction
        req_d = 1'b1; we_d = 1'b0; addr_d = 8'h55;
        settle();
        chk("r_gnt_d", {31'd0, gnt_d}, 32'd1);
        adv();
        req_d = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_mem_en", {31'd0, mem_en}, 32'd0);
        chk("r_mem_we", {31'd0, mem_we}, 32'd0);
        chk("r_done", {30'd0, done_f, done_d}, 32'd0);
        chk("r_rdata", {16'd0, rdata}, 32'd0);
        chk("r_mem_addr", {24'd0, mem_addr}, 32'd0);
        adv();
        dn_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (done_f || done_d) dn_cnt++;
            adv();
        end
        chk("r_no_done", dn_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
